// File: rtl/priority_encoder_stream.sv
// priority_encoder_stream
//  Captures an N-bit request bitmap and streams the index of every set bit,
//  one per out_valid/out_ready handshake, in priority order (highest index
//  first unless LSB_FIRST=1).
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  in_valid/in_ready   bitmap handshake; in_vec is the request bitmap
//  out_valid/out_ready index handshake; out_idx is the current index,
//                      out_last marks the final pending bit
//  vec_count           popcount of the last accepted bitmap
//  err_zero            one-cycle pulse after an all-zero bitmap is accepted
module priority_encoder_stream #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = $clog2(N),
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic [W:0]   vec_count,
    output logic         err_zero
);

    localparam int unsigned CW = W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW-1:0] vec_count_q, vec_count_d;
    logic          err_zero_q, err_zero_d;
    logic [W-1:0]  sel_idx;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // Priority select: the last match in scan order wins, so scan toward the
    // winning end.
    always_comb begin
        sel_idx = '0;
        if (LSB_FIRST) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pending_q[i]) sel_idx = W'(i);
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (pending_q[i]) sel_idx = W'(i);
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = (popcount(pending_q) == CW'(1));
    assign vec_count = vec_count_q;
    assign err_zero  = err_zero_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        vec_count_d = vec_count_q;
        err_zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d   = in_vec;
                    vec_count_d = popcount(in_vec);
                    if (in_vec != '0) begin
                        state_d = EMIT;
                    end else begin
                        err_zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(N'(1) << sel_idx);
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            vec_count_q <= '0;
            err_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            vec_count_q <= vec_count_d;
            err_zero_q  <= err_zero_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Bench for priority_encoder_stream: two N=8 instances (MSB-first and
// LSB-first) driven in lockstep, plus an N=5 instance for reset-mid-stream.
module tb_priority_encoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_m, out_valid_m, out_last_m, err_zero_m;
    logic [2:0] out_idx_m;
    logic [3:0] vec_count_m;
    logic       in_ready_l, out_valid_l, out_last_l, err_zero_l;
    logic [2:0] out_idx_l;
    logic [3:0] vec_count_l;

    logic       rst5, in_valid5, out_ready5;
    logic [4:0] in_vec5;
    logic       in_ready5, out_valid5, out_last5, err_zero5;
    logic [2:0] out_idx5;
    logic [3:0] vec_count5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    priority_encoder_stream #(.N(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .out_last(out_last_m), .vec_count(vec_count_m),
        .err_zero(err_zero_m)
    );

    priority_encoder_stream #(.N(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_idx(out_idx_l), .out_last(out_last_l), .vec_count(vec_count_l),
        .err_zero(err_zero_l)
    );

    priority_encoder_stream #(.N(5), .LSB_FIRST(1'b0)) dut_5 (
        .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_vec(in_vec5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_idx(out_idx5), .out_last(out_last5), .vec_count(vec_count5),
        .err_zero(err_zero5)
    );

    typedef struct {
        logic [7:0] vec;
        int         mode;   // 0: out_ready=1, 1: 1,0,0 pattern, 2: random
        logic [2:0] first_m;
        logic [2:0] first_l;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Accepts v on both N=8 instances and follows the whole stream against
    // an index list derived directly from the bitmap.
    task automatic send_vec(input logic [7:0] v, input int mode, input bit has_exp,
                            input logic [2:0] fm, input logic [2:0] fl, input logic [3:0] cnt);
        int qm[$];
        int ql[$];
        int guard;
        int k;
        int pc;
        guard = 0;
        while (!(in_ready_m && in_ready_l) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) fail("accept_wait");
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 8'($urandom);

        pc = 0;
        for (int i = 7; i >= 0; i--) if (v[i]) begin qm.push_back(i); pc++; end
        for (int i = 0; i < 8; i++) if (v[i]) ql.push_back(i);

        chk("vec_count_m", 32'(vec_count_m), 32'(pc));
        chk("vec_count_l", 32'(vec_count_l), 32'(pc));
        if (has_exp) begin
            chk("tbl_count", 32'(vec_count_m), 32'(cnt));
            if (v != 8'h00) begin
                chk("tbl_first_m", 32'(out_idx_m), 32'(fm));
                chk("tbl_first_l", 32'(out_idx_l), 32'(fl));
            end
        end
        if (v == 8'h00) begin
            chk("err_zero_m", 32'(err_zero_m), 1);
            chk("err_zero_l", 32'(err_zero_l), 1);
            chk("zero_out_valid", 32'(out_valid_m), 0);
            chk("zero_in_ready", 32'(in_ready_m), 1);
            @(negedge clk);
            chk("err_zero_pulse", 32'(err_zero_m), 0);
            chk("zero_out_valid2", 32'(out_valid_m), 0);
            chk("zero_in_ready2", 32'(in_ready_m), 1);
            return;
        end
        chk("err_zero_nz", 32'(err_zero_m), 0);
        chk("in_ready_busy", 32'(in_ready_m), 0);

        k = 0;
        guard = 0;
        while (qm.size() > 0 && guard < 200) begin
            chk("out_valid_m", 32'(out_valid_m), 1);
            chk("out_valid_l", 32'(out_valid_l), 1);
            chk("out_idx_m", 32'(out_idx_m), 32'(qm[0]));
            chk("out_idx_l", 32'(out_idx_l), 32'(ql[0]));
            chk("out_last_m", 32'(out_last_m), 32'(qm.size() == 1));
            chk("out_last_l", 32'(out_last_l), 32'(ql.size() == 1));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    in_valid  = 1'($urandom_range(0, 1));
                    in_vec    = 8'($urandom);
                end
            endcase
            k++;
            @(negedge clk);
            guard++;
            if (out_ready) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
        end
        if (qm.size() > 0) fail("stream_wait");
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("end_out_valid_m", 32'(out_valid_m), 0);
        chk("end_out_valid_l", 32'(out_valid_l), 0);
        chk("end_in_ready_m", 32'(in_ready_m), 1);
        chk("end_in_ready_l", 32'(in_ready_l), 1);
        chk("vec_count_hold", 32'(vec_count_m), 32'(pc));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{8'(1 << i), 0, 3'(i), 3'(i), 4'd1};
        end
        tbl[8]  = '{8'hA6, 0, 3'd7, 3'd1, 4'd4};
        tbl[9]  = '{8'hFF, 1, 3'd7, 3'd0, 4'd8};
        tbl[10] = '{8'h00, 0, 3'd0, 3'd0, 4'd0};

        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        rst5 = 1'b1; in_valid5 = 1'b0; in_vec5 = '0; out_ready5 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_m), 0);
        chk("rst_out_valid", 32'(out_valid_m), 0);
        chk("rst_out_idx", 32'(out_idx_m), 0);
        chk("rst_out_last", 32'(out_last_m), 0);
        chk("rst_vec_count", 32'(vec_count_m), 0);
        chk("rst_err_zero", 32'(err_zero_l), 0);
        chk("rst_out_valid5", 32'(out_valid5), 0);
        chk("rst_err_zero5", 32'(err_zero5), 0);
        rst = 1'b0;
        rst5 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_m), 1);

        foreach (tbl[i]) begin
            send_vec(tbl[i].vec, tbl[i].mode, 1'b1, tbl[i].first_m, tbl[i].first_l, tbl[i].cnt);
        end

        for (int n = 0; n < 40; n++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (n % 10 == 0) v = 8'h00;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_vec(v, 2, 1'b0, 3'd0, 3'd0, 4'd0);
        end

        // N=5: reset after the second beat, then a fresh single-bit bitmap
        chk("n5_in_ready", 32'(in_ready5), 1);
        in_valid5 = 1'b1;
        in_vec5   = 5'b11111;
        @(negedge clk);
        in_valid5 = 1'b0;
        chk("n5_vec_count", 32'(vec_count5), 5);
        chk("n5_idx_a", 32'(out_idx5), 4);
        chk("n5_last_a", 32'(out_last5), 0);
        out_ready5 = 1'b1;
        @(negedge clk);
        chk("n5_idx_b", 32'(out_idx5), 3);
        @(negedge clk);
        chk("n5_idx_c", 32'(out_idx5), 2);
        rst5 = 1'b1;
        @(negedge clk);
        chk("n5_rst_out_valid", 32'(out_valid5), 0);
        chk("n5_rst_vec_count", 32'(vec_count5), 0);
        chk("n5_rst_in_ready", 32'(in_ready5), 0);
        chk("n5_rst_last", 32'(out_last5), 0);
        rst5 = 1'b0;
        out_ready5 = 1'b0;
        @(negedge clk);
        chk("n5_in_ready_after", 32'(in_ready5), 1);
        chk("n5_out_valid_after", 32'(out_valid5), 0);
        in_valid5 = 1'b1;
        in_vec5   = 5'b00100;
        @(negedge clk);
        in_valid5 = 1'b0;
        chk("n5_single_valid", 32'(out_valid5), 1);
        chk("n5_single_idx", 32'(out_idx5), 2);
        chk("n5_single_last", 32'(out_last5), 1);
        chk("n5_single_count", 32'(vec_count5), 1);
        out_ready5 = 1'b1;
        @(negedge clk);
        out_ready5 = 1'b0;
        chk("n5_done_valid", 32'(out_valid5), 0);
        chk("n5_done_in_ready", 32'(in_ready5), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
